// File: rtl/card_pkg.sv
// Shared constants, FSM state type and LFSR taps for the card dealer.
// The deck geometry lives here so the top and the LFSR agree on slot folding.
package card_pkg;

    localparam int DECK_SIZE   = 52;
    localparam int SUIT_SIZE   = 13;
    localparam int LFSR_W      = 6;
    localparam int LFSR_TAP_HI = 5;
    localparam int LFSR_TAP_LO = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        DEAL  = 2'd2
    } state_t;

    // Fold a 6-bit LFSR value (1..63) onto a deck slot 0..51.
    function automatic logic [5:0] fold_slot(input logic [5:0] v);
        return (v >= 6'(DECK_SIZE)) ? v - 6'(DECK_SIZE) : v;
    endfunction

endpackage

// File: rtl/deal_lfsr.sv
// Free-running 6-bit Fibonacci LFSR used to pick the probe start slot.
// Advances every cycle out of reset; SEED must be nonzero.
module deal_lfsr
    import card_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 6'h01
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic [LFSR_W-1:0] o_lfsr
);

    logic [LFSR_W-1:0] r_lfsr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {r_lfsr[LFSR_W-2:0], r_lfsr[LFSR_TAP_HI] ^ r_lfsr[LFSR_TAP_LO]};
        end
    end

    assign o_lfsr = r_lfsr;

endmodule

// File: rtl/card_dealer.sv
// Round-robin card dealer: deals each of 52 cards once per deck using an LFSR start slot
// plus linear probe. Define CARD_DECODE_EN to register suit/rank; otherwise they read 0.
module card_dealer
    import card_pkg::*;
#(
    parameter int          NUM_REQ   = 2,
    parameter logic [5:0]  LFSR_SEED = 6'h01
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               new_deck,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] ack,
    output logic               card_valid,
    output logic [5:0]         card_bit,
    output logic [1:0]         card_flower,
    output logic [3:0]         card_number,
    output logic [5:0]         cards_left,
    output logic               deck_empty,
    output logic               busy,
    output logic [1:0]         dbg_state
);

    localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t                r_state;
    logic [DECK_SIZE-1:0]  r_used;
    logic [5:0]            r_left;
    logic [RR_W-1:0]       r_rr;
    logic [RR_W-1:0]       r_winner;
    logic [5:0]            r_idx;
    logic [NUM_REQ-1:0]    r_ack;
    logic                  r_valid;
    logic [5:0]            r_card;

    logic [LFSR_W-1:0]     w_lfsr;
    logic                  w_any;
    logic [RR_W-1:0]       w_winner;
    int                    w_pos;

    deal_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .o_lfsr  (w_lfsr)
    );

    // Scan from the highest offset down so the lowest offset from r_rr wins.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        w_pos    = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_pos = (int'(r_rr) + k) % NUM_REQ;
            if (req[w_pos]) begin
                w_any    = 1'b1;
                w_winner = RR_W'(w_pos);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_used   <= '0;
            r_left   <= 6'(DECK_SIZE);
            r_rr     <= '0;
            r_winner <= '0;
            r_idx    <= '0;
            r_ack    <= '0;
            r_valid  <= 1'b0;
            r_card   <= '0;
        end else begin
            r_ack   <= '0;
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (new_deck) begin
                        r_used <= '0;
                        r_left <= 6'(DECK_SIZE);
                    end else if (w_any && (r_left != '0)) begin
                        r_winner <= w_winner;
                        r_idx    <= fold_slot(w_lfsr);
                        r_state  <= PROBE;
                    end
                end
                PROBE: begin
                    // Guaranteed to find a free slot because r_left was nonzero.
                    if (r_used[r_idx]) begin
                        r_idx <= (r_idx == 6'(DECK_SIZE - 1)) ? 6'd0 : r_idx + 6'd1;
                    end else begin
                        r_state <= DEAL;
                    end
                end
                DEAL: begin
                    r_used[r_idx] <= 1'b1;
                    r_left        <= r_left - 6'd1;
                    r_card        <= r_idx;
                    r_valid       <= 1'b1;
                    r_ack         <= NUM_REQ'(1) << r_winner;
                    r_rr          <= (r_winner == RR_W'(NUM_REQ - 1)) ? '0 : r_winner + 1'b1;
                    r_state       <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef CARD_DECODE_EN
    logic [1:0] r_flower;
    logic [3:0] r_number;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flower <= '0;
            r_number <= '0;
        end else if (r_state == DEAL) begin
            r_flower <= 2'(r_idx / 6'(SUIT_SIZE));
            r_number <= 4'(r_idx % 6'(SUIT_SIZE));
        end
    end

    assign card_flower = r_flower;
    assign card_number = r_number;
`else
    assign card_flower = 2'd0;
    assign card_number = 4'd0;
`endif

    assign ack        = r_ack;
    assign card_valid = r_valid;
    assign card_bit   = r_card;
    assign cards_left = r_left;
    assign deck_empty = (r_left == '0);
    assign busy       = (r_state != IDLE);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: cycle model feeds an expected-deal queue that a
// negedge monitor pops on every card_valid; directed tasks cover deck, arbitration and reset cases.
module tb_card_dealer;

    localparam int NUM_REQ = 2;
    localparam int EW      = NUM_REQ + 6 + 2 + 4 + 6 + 1;
`ifdef CARD_DECODE_EN
    localparam bit DEC = 1'b1;
`else
    localparam bit DEC = 1'b0;
`endif

    logic               clk;
    logic               rst_n;
    logic               new_deck;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] ack;
    logic               card_valid;
    logic [5:0]         card_bit;
    logic [1:0]         card_flower;
    logic [3:0]         card_number;
    logic [5:0]         cards_left;
    logic               deck_empty;
    logic               busy;
    logic [1:0]         dbg_state;

    int checks = 0;
    int errors = 0;

    card_dealer #(
        .NUM_REQ   (NUM_REQ),
        .LFSR_SEED (6'h01)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .new_deck    (new_deck),
        .req         (req),
        .ack         (ack),
        .card_valid  (card_valid),
        .card_bit    (card_bit),
        .card_flower (card_flower),
        .card_number (card_number),
        .cards_left  (cards_left),
        .deck_empty  (deck_empty),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference model state: values the DUT should hold in the current cycle
    logic [EW-1:0] exp_q[$];
    int            m_st;
    logic [51:0]   m_used;
    int            m_left;
    logic [5:0]    m_lfsr;
    int            m_rr;
    int            m_win;
    int            m_idx;
    bit            m_valid;

    function automatic logic [EW-1:0] pack_exp(input int win, input int idx, input int left);
        logic [1:0] f;
        logic [3:0] nb;
        logic [NUM_REQ-1:0] a;
        f  = DEC ? 2'(idx / 13) : 2'd0;
        nb = DEC ? 4'(idx % 13) : 4'd0;
        a  = NUM_REQ'(1) << win;
        return {a, 6'(idx), f, nb, 6'(left), (left == 0)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, expv);
        end
    endtask

    // monitor + model step, both at negedge (monitor first, then advance the model)
    always @(negedge clk) begin
        logic [EW-1:0] e;
        logic [EW-1:0] got;
        bit found;
        if (!rst_n) begin
            m_st = 0; m_used = '0; m_left = 52; m_lfsr = 6'h01;
            m_rr = 0; m_win = 0; m_idx = 0; m_valid = 0;
            exp_q.delete();
        end else begin
            checks++;
            if (busy !== (m_st != 0)) begin
                errors++;
                $display("FAIL mon_busy: got %0b required %0b", busy, (m_st != 0));
            end
            checks++;
            if (cards_left !== 6'(m_left)) begin
                errors++;
                $display("FAIL mon_cards_left: got %0d required %0d", cards_left, m_left);
            end
            got = {ack, card_bit, card_flower, card_number, cards_left, deck_empty};
            if (card_valid || m_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL mon_unexpected_deal: got %h required no deal", got);
                end else begin
                    e = exp_q.pop_front();
                    if (card_valid !== 1'b1 || got !== e) begin
                        errors++;
                        $display("FAIL mon_deal: valid %0b got %h required %h", card_valid, got, e);
                    end
                end
            end else begin
                checks++;
                if (ack !== '0) begin
                    errors++;
                    $display("FAIL mon_stray_ack: got %b required 0", ack);
                end
            end

            m_valid = 0;
            case (m_st)
                0: begin
                    if (new_deck) begin
                        m_used = '0;
                        m_left = 52;
                    end else if (req != '0 && m_left != 0) begin
                        found = 0;
                        for (int k = 0; k < NUM_REQ; k++) begin
                            if (!found && req[(m_rr + k) % NUM_REQ]) begin
                                m_win = (m_rr + k) % NUM_REQ;
                                found = 1;
                            end
                        end
                        m_idx = (int'(m_lfsr) >= 52) ? int'(m_lfsr) - 52 : int'(m_lfsr);
                        m_st  = 1;
                    end
                end
                1: begin
                    if (m_used[m_idx]) m_idx = (m_idx == 51) ? 0 : m_idx + 1;
                    else m_st = 2;
                end
                default: begin
                    m_used[m_idx] = 1'b1;
                    m_left        = m_left - 1;
                    exp_q.push_back(pack_exp(m_win, m_idx, m_left));
                    m_rr          = (m_win + 1) % NUM_REQ;
                    m_valid       = 1;
                    m_st          = 0;
                end
            endcase
            m_lfsr = {m_lfsr[4:0], m_lfsr[5] ^ m_lfsr[4]};
        end
    end

    // driver tasks
    task automatic wait_any_ack(input int budget, output bit ok, output logic [NUM_REQ-1:0] got);
        ok  = 0;
        got = '0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(posedge clk);
            #1;
            if (ack != '0) begin
                ok  = 1;
                got = ack;
            end
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [51:0] seen;
        logic [NUM_REQ-1:0] got;
        bit ok;
        int last;
        int cnt;

        rst_n = 1'b0;
        new_deck = 1'b0;
        req = '0;
        repeat (3) idle_cycle();
        rst_n = 1'b1;

        // reset values
        check("rst_cards_left", cards_left, 52);
        check("rst_deck_empty", deck_empty, 0);
        check("rst_busy", busy, 0);
        check("rst_ack", ack, 0);
        check("rst_card_valid", card_valid, 0);
        check("rst_card_bit", card_bit, 0);
        check("rst_card_flower", card_flower, 0);
        check("rst_card_number", card_number, 0);

        // deal the whole deck to requester 0
        seen = '0;
        for (int n = 0; n < 52; n++) begin
            last = -1;
            for (int c = 0; c < 52; c++) if (!seen[c]) last = c;
            req[0] = 1'b1;
            wait_any_ack(60, ok, got);
            req = '0;
            check("deal_ack_seen", ok, 1);
            if (ok) begin
                check("deal_ack_req0", got, 2'b01);
                check("card_unique", seen[card_bit], 0);
                seen[card_bit] = 1'b1;
                check("cards_left_count", cards_left, 51 - n);
                if (card_bit == 6'd51) begin
                    check("card51_flower", card_flower, DEC ? 3 : 0);
                    check("card51_number", card_number, DEC ? 12 : 0);
                end
                if (card_bit == 6'd13) begin
                    check("card13_flower", card_flower, DEC ? 1 : 0);
                    check("card13_number", card_number, 0);
                end
                if (n == 51) check("last_card_index", card_bit, last);
            end
            idle_cycle();
        end
        check("all_cards_seen", (seen == {52{1'b1}}), 1);
        check("empty_cards_left", cards_left, 0);
        check("empty_flag", deck_empty, 1);

        // empty deck: request must stay pending without a grant
        req[1] = 1'b1;
        cnt = 0;
        repeat (100) begin
            idle_cycle();
            if (ack != '0) cnt++;
        end
        check("empty_no_ack", cnt, 0);
        check("empty_not_busy", busy, 0);

        // renew with busy low, requester 1 still waiting
        new_deck = 1'b1;
        idle_cycle();
        new_deck = 1'b0;
        check("renew_cards_left", cards_left, 52);
        check("renew_deck_empty", deck_empty, 0);
        wait_any_ack(54, ok, got);
        check("renew_ack_within_54", ok, 1);
        check("renew_ack_req1", got, 2'b10);
        req = '0;
        idle_cycle();

        // both requesters held: grants alternate starting at 0
        req = 2'b11;
        for (int i = 0; i < 6; i++) begin
            wait_any_ack(60, ok, got);
            check("rr_ack_seen", ok, 1);
            check("rr_ack_order", got, (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        req = '0;
        idle_cycle();
        check("rr_cards_left", cards_left, 45);

        // reset while probing aborts the deal and restores the deck
        req[0] = 1'b1;
        ok = 0;
        for (int c = 0; c < 5 && !ok; c++) begin
            idle_cycle();
            if (busy) ok = 1;
        end
        check("probe_entered", ok, 1);
        rst_n = 1'b0;
        req = '0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_cards_left", cards_left, 52);
        check("abort_card_valid", card_valid, 0);
        check("abort_ack", ack, 0);
        idle_cycle();
        rst_n = 1'b1;
        cnt = 0;
        repeat (6) begin
            idle_cycle();
            if (card_valid) cnt++;
        end
        check("abort_no_valid", cnt, 0);
        check("abort_left_after", cards_left, 52);

        // dealing resumes normally after the abort
        req[1] = 1'b1;
        wait_any_ack(60, ok, got);
        req = '0;
        check("post_reset_ack", ok, 1);
        check("post_reset_ack_req1", got, 2'b10);
        check("post_reset_left", cards_left, 51);
        repeat (4) idle_cycle();
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/card_dealer.md
# card_dealer

Deals cards from a single 52-card deck to up to NUM_REQ requesters (player/banker seats), never dealing the same card twice until the deck is renewed. A free-running LFSR picks a start slot, and a linear probe skips cards already dealt. Requests are granted round-robin. Each dealt card leaves as a 6-bit index (0..51) plus its decoded suit/rank, feeding the game FSM and the display path.

## Interface
Parameters:
- NUM_REQ, 2: number of requesters, 1..4.
- LFSR_SEED, 6'h01: LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock; one clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- new_deck  in  1  one-cycle pulse: mark all 52 cards available.
- req  in  NUM_REQ  per-requester deal request, level, held until ack.
- ack  out  NUM_REQ  one-hot, one-cycle pulse: card delivered to that requester.
- card_valid  out  1  one-cycle pulse, coincident with ack.
- card_bit  out  6  dealt card index 0..51, held until next deal.
- card_flower  out  2  suit = card_bit / 13.
- card_number  out  4  rank = card_bit % 13 (0..12).
- cards_left  out  6  undealt cards, 0..52.
- deck_empty  out  1  cards_left == 0.
- busy  out  1  state != IDLE.

## Operation
- State: used[51:0] mask, cards_left, rr pointer, 6-bit LFSR, winner index, probe index idx.
- LFSR: advances every cycle, including while idle. next = {lfsr[4:0], lfsr[5]^lfsr[4]}.
- FSM states: IDLE, PROBE, DEAL.
- IDLE:
  - If new_deck: used <= 0, cards_left <= 52, stay in IDLE; req is ignored that cycle.
  - Else if |req and !deck_empty: winner = first asserted req at or after rr, wrapping. idx <= (lfsr >= 52) ? lfsr - 52 : lfsr. Go to PROBE.
  - Else stay.
- PROBE:
  - If used[idx]: idx <= (idx == 51) ? 0 : idx + 1, and stay.
  - Else go to DEAL.
  - Termination is guaranteed because cards_left > 0.
- DEAL:
  - used[idx] <= 1, cards_left <= cards_left - 1.
  - card_bit <= idx (decoded outputs follow), card_valid and ack[winner] pulse.
  - rr <= winner + 1, wrapping mod NUM_REQ. Go to IDLE.
- new_deck outside IDLE is ignored (not latched). The controller must wait for busy low.
- deck_empty with req pending: no grant and no ack; req stays pending until new_deck.
- req is sampled only in IDLE. A requester still holding req in the cycle after its ack is treated as a new request.
- Arithmetic: cards_left never underflows, because a deal only starts when it is nonzero. idx wraps from 51 to 0.

## Timing
- Reset values: state IDLE, used all 0, cards_left 52, deck_empty 0, busy 0, ack 0, card_valid 0, card_bit 0, card_flower 0, card_number 0, rr 0, lfsr LFSR_SEED.
- Outputs are registered. ack/card_valid/card_bit update at the edge leaving DEAL, so they are visible in the IDLE cycle after DEAL.
- Latency, req seen in IDLE at edge N to ack high:
  - minimum 3 edges (N: to PROBE, N+1: to DEAL, N+2: ack registered);
  - maximum 3 + 51 edges (full probe).
- cards_left and deck_empty update in the same cycle as ack.
- Reset asserted mid-PROBE or mid-DEAL aborts immediately: no ack, card not consumed, full deck restored.
- Throughput: at most one card per 3 cycles.

## Configuration
- CARD_DECODE_EN defined: card_flower and card_number are registered alongside card_bit, using /13 and %13 on idx.
- CARD_DECODE_EN undefined: the decode logic is removed and card_flower/card_number are tied to 0. Ports remain, and all other behaviour is unchanged.

## Structure
- Package card_pkg holds:
  - DECK_SIZE = 52 and SUIT_SIZE = 13;
  - the state enum (IDLE, PROBE, DEAL);
  - the LFSR tap constants.
- One sub-module: deal_lfsr (6-bit free-running LFSR with seed parameter, async active-low reset).
- Arbitration, probe and mask logic stay in card_dealer.

## Test plan
- Reset, then req[0] held and dropped after each ack, 52 times: every card_bit 0..51 appears exactly once. cards_left counts 52 down to 0, then deck_empty = 1.
- Empty deck, req[1] held for 100 cycles: no ack. Then new_deck with busy low: cards_left = 52 and ack[1] within 54 cycles.
- req = 2'b11 held continuously after reset: acks alternate ack[0], ack[1], ack[0], ...
- Force a deal whose card_bit = 51: card_flower = 3, card_number = 12. Card 13: flower 1, number 0. Without CARD_DECODE_EN, both read 0.
- 51 cards dealt, then deal the last: probe wraps through 51 to 0 if needed. The last ack carries the single remaining index.
- rst_n low during PROBE: next cycle busy = 0, cards_left = 52, no card_valid pulse.
